// File: rtl/lcd_char_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_char_arbiter
//
// Shares the single LCD character-render engine (show_char) between N_REQ
// screen-content generators. One requester at a time holds a burst-level
// grant; the next winner is picked round-robin. The granted requester's
// character command and colours are registered onto the engine inputs, and the
// engine's completion pulse is routed back to that requester only. A watchdog
// revokes a grant that sits idle (no character issued) for TIMEOUT cycles.
//
// Ports
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   init_done            LCD init complete; gates new grants
//   req / gnt            per-requester burst request (level) / one-hot grant
//   req_flag             per-requester character-start pulse
//   req_ascii/x/y/bg/fg  per-requester packed command slices (fixed width)
//   req_size             per-requester font select
//   req_done             engine done routed to the granted requester
//   show_char_done       engine completion pulse
//   show_char_flag       engine start pulse (registered, one cycle)
//   ascii_num, start_x, start_y, background_color, front_color, en_size
//                        registered command to the engine
//   timeout_err          one-cycle pulse when the watchdog revokes a grant
//
// State table
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   S_IDLE    | no grant; arbitrate when init_done and any req is high
//   S_GRANT   | grant held, waiting for the owner's next req_flag; watchdog on
//   S_BUSY    | character in flight; command frozen, waiting show_char_done
//   S_RELEASE | one cycle: drop gnt, restore default colours, advance rr_ptr
// ---------------------------------------------------------------------------
module lcd_char_arbiter #(
    parameter int          N_REQ   = 2,
    parameter int          TIMEOUT = 1024,
    parameter logic [15:0] DEF_BG  = 16'hE73F,
    parameter logic [15:0] DEF_FG  = 16'h0000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  init_done,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    input  logic [N_REQ-1:0]      req_flag,
    input  logic [N_REQ*8-1:0]    req_ascii,
    input  logic [N_REQ*9-1:0]    req_x,
    input  logic [N_REQ*9-1:0]    req_y,
    input  logic [N_REQ*16-1:0]   req_bg,
    input  logic [N_REQ*16-1:0]   req_fg,
    input  logic [N_REQ-1:0]      req_size,
    output logic [N_REQ-1:0]      req_done,
    input  logic                  show_char_done,
    output logic                  show_char_flag,
    output logic [7:0]            ascii_num,
    output logic [8:0]            start_x,
    output logic [8:0]            start_y,
    output logic [15:0]           background_color,
    output logic [15:0]           front_color,
    output logic                  en_size,
    output logic                  timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [WD_W-1:0]  WD_TC    = WD_W'(TIMEOUT - 1);
    localparam logic [SUM_W-1:0] N_SUM    = SUM_W'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] gidx;     // index of the current owner
    logic [IDX_W-1:0] rr_ptr;   // where the next search starts: last winner + 1
    logic [WD_W-1:0]  wd;

    // Unpacked views of the packed request buses so the granted slice is a
    // plain array select.
    logic [7:0]  ascii_arr [N_REQ];
    logic [8:0]  x_arr     [N_REQ];
    logic [8:0]  y_arr     [N_REQ];
    logic [15:0] bg_arr    [N_REQ];
    logic [15:0] fg_arr    [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign ascii_arr[i] = req_ascii[8*i +: 8];
        assign x_arr[i]     = req_x[9*i +: 9];
        assign y_arr[i]     = req_y[9*i +: 9];
        assign bg_arr[i]    = req_bg[16*i +: 16];
        assign fg_arr[i]    = req_fg[16*i +: 16];
    end

    // Round-robin search: scan N_REQ candidates starting at rr_ptr, wrapping
    // modulo N_REQ. One extra bit on the sum keeps the wrap correct when
    // N_REQ is not a power of two.
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [SUM_W-1:0] cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_idx   = rr_ptr;
        win_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand_sum >= N_SUM) begin
                cand_sum = cand_sum - N_SUM;
            end
            cand = cand_sum[IDX_W-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Done goes straight back to whoever holds the grant, with no latency.
    assign req_done = gnt & {N_REQ{show_char_done}};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state            <= S_IDLE;
            gnt              <= '0;
            gidx             <= '0;
            rr_ptr           <= '0;
            wd               <= '0;
            show_char_flag   <= 1'b0;
            ascii_num        <= '0;
            start_x          <= '0;
            start_y          <= '0;
            background_color <= DEF_BG;
            front_color      <= DEF_FG;
            en_size          <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            show_char_flag <= 1'b0;
            timeout_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_done && win_found) begin
                        gnt   <= ONE_HOT0 << win_idx;
                        gidx  <= win_idx;
                        wd    <= '0;
                        state <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    // A start flag beats a simultaneous req drop and an
                    // expiring watchdog; the release happens after that
                    // character completes.
                    if (req_flag[gidx]) begin
                        ascii_num        <= ascii_arr[gidx];
                        start_x          <= x_arr[gidx];
                        start_y          <= y_arr[gidx];
                        background_color <= bg_arr[gidx];
                        front_color      <= fg_arr[gidx];
                        en_size          <= req_size[gidx];
                        show_char_flag   <= 1'b1;
                        wd               <= '0;
                        state            <= S_BUSY;
                    end else if (!req[gidx]) begin
                        state <= S_RELEASE;
                    end else if (wd == WD_TC) begin
                        timeout_err <= 1'b1;
                        state       <= S_RELEASE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end

                S_BUSY: begin
                    // Command registers stay frozen; any req_flag is dropped.
                    if (show_char_done) begin
                        state <= req[gidx] ? S_GRANT : S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    gnt              <= '0;
                    rr_ptr           <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
                    background_color <= DEF_BG;
                    front_color      <= DEF_FG;
                    wd               <= '0;
                    state            <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_char_arbiter
//
// Bench for lcd_char_arbiter (N_REQ=2, TIMEOUT=16). A transaction-level model
// tracks who owns the engine, whether a character is in flight, whether the
// owner is on its way out, and how long the owner has idled; the expected
// outputs follow from that. A negedge process compares every output against
// the model on every cycle. Directed scenarios add literal expectations, then
// a randomized phase exercises requests, flags, init gating, stray dones and
// resets.
// ---------------------------------------------------------------------------
module tb_lcd_char_arbiter;

    localparam int          N      = 2;
    localparam int          TO     = 16;
    localparam logic [15:0] DEF_BG = 16'hE73F;
    localparam logic [15:0] DEF_FG = 16'h0000;
    localparam int          AW     = N * 8;
    localparam int          XW     = N * 9;
    localparam int          CW     = N * 16;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          init_done;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  req_flag;
    logic [AW-1:0] req_ascii;
    logic [XW-1:0] req_x;
    logic [XW-1:0] req_y;
    logic [CW-1:0] req_bg;
    logic [CW-1:0] req_fg;
    logic [N-1:0]  req_size;
    logic [N-1:0]  req_done;
    logic          show_char_done;
    logic          show_char_flag;
    logic [7:0]    ascii_num;
    logic [8:0]    start_x;
    logic [8:0]    start_y;
    logic [15:0]   background_color;
    logic [15:0]   front_color;
    logic          en_size;
    logic          timeout_err;

    always #5 clk = ~clk;

    lcd_char_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO),
        .DEF_BG  (DEF_BG),
        .DEF_FG  (DEF_FG)
    ) dut (
        .sys_clk          (clk),
        .sys_rst          (sys_rst),
        .init_done        (init_done),
        .req              (req),
        .gnt              (gnt),
        .req_flag         (req_flag),
        .req_ascii        (req_ascii),
        .req_x            (req_x),
        .req_y            (req_y),
        .req_bg           (req_bg),
        .req_fg           (req_fg),
        .req_size         (req_size),
        .req_done         (req_done),
        .show_char_done   (show_char_done),
        .show_char_flag   (show_char_flag),
        .ascii_num        (ascii_num),
        .start_x          (start_x),
        .start_y          (start_y),
        .background_color (background_color),
        .front_color      (front_color),
        .en_size          (en_size),
        .timeout_err      (timeout_err)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: ownership / in-flight / leaving / idle-time view.
    // ------------------------------------------------------------------
    int          m_owner   = -1;
    bit          m_busy    = 1'b0;
    bit          m_leaving = 1'b0;
    int          m_wait    = 0;
    int          m_next    = 0;
    logic [7:0]  m_ascii   = '0;
    logic [8:0]  m_x       = '0;
    logic [8:0]  m_y       = '0;
    logic [15:0] m_bg      = DEF_BG;
    logic [15:0] m_fg      = DEF_FG;
    logic        m_size    = 1'b0;
    logic        m_flag    = 1'b0;
    logic        m_terr    = 1'b0;

    always @(posedge clk) begin
        int c;
        if (sys_rst) begin
            m_owner = -1; m_busy = 0; m_leaving = 0; m_wait = 0; m_next = 0;
            m_ascii = '0; m_x = '0; m_y = '0; m_size = 1'b0;
            m_bg = DEF_BG; m_fg = DEF_FG; m_flag = 1'b0; m_terr = 1'b0;
        end else begin
            m_flag = 1'b0;
            m_terr = 1'b0;
            if (m_owner < 0) begin
                if (init_done && req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_next + k) % N;
                        if (req[c]) begin
                            m_owner = c;
                            m_wait  = 0;
                            break;
                        end
                    end
                end
            end else if (m_leaving) begin
                m_next    = (m_owner + 1) % N;
                m_owner   = -1;
                m_leaving = 1'b0;
                m_bg      = DEF_BG;
                m_fg      = DEF_FG;
            end else if (m_busy) begin
                if (show_char_done) begin
                    m_busy    = 1'b0;
                    m_leaving = !req[m_owner];
                end
            end else if (req_flag[m_owner]) begin
                m_ascii = req_ascii[m_owner*8 +: 8];
                m_x     = req_x[m_owner*9 +: 9];
                m_y     = req_y[m_owner*9 +: 9];
                m_bg    = req_bg[m_owner*16 +: 16];
                m_fg    = req_fg[m_owner*16 +: 16];
                m_size  = req_size[m_owner];
                m_flag  = 1'b1;
                m_busy  = 1'b1;
                m_wait  = 0;
            end else if (!req[m_owner]) begin
                m_leaving = 1'b1;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_terr    = 1'b1;
                    m_leaving = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (cmp_en) begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            chk("gnt", gnt, eg);
            chk("req_done", req_done, eg & {N{show_char_done}});
            chk("show_char_flag", show_char_flag, m_flag);
            chk("timeout_err", timeout_err, m_terr);
            chk("ascii_num", ascii_num, m_ascii);
            chk("start_x", start_x, m_x);
            chk("start_y", start_y, m_y);
            chk("background_color", background_color, m_bg);
            chk("front_color", front_color, m_fg);
            chk("en_size", en_size, m_size);
        end
    end

    // ------------------------------------------------------------------
    // Engine stand-in: done eng_lat cycles after each start pulse, plus
    // optional stray dones.
    // ------------------------------------------------------------------
    int eng_cnt  = 0;
    int eng_lat  = 20;
    bit stray_en = 1'b0;

    initial begin
        show_char_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            show_char_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) show_char_done = 1'b1;
            end else if (stray_en && $urandom_range(0, 49) == 0) begin
                show_char_done = 1'b1;
            end
            if (show_char_flag === 1'b1) eng_cnt = eng_lat;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        sys_rst  = 1'b1;
        req      = '0;
        req_flag = '0;
        eng_cnt  = 0;
        repeat (2) step();
        sys_rst  = 1'b0;
    endtask

    task automatic wait_grant(input string nm, input logic [N-1:0] exp);
        for (int k = 0; k < 20 && gnt == '0; k++) step();
        chk(nm, gnt, exp);
    endtask

    // ------------------------------------------------------------------
    // Round-robin scenario: both request, each burst is three characters,
    // then the requester drops req and re-requests once released.
    // ------------------------------------------------------------------
    task automatic run_rr();
        int           order[$];
        int           gaps[$];
        int           zero_run;
        logic [N-1:0] prev_gnt;
        int           ndone [N];
        bit           pending [N];
        bit           dropped [N];
        reset_dut();
        eng_lat  = 4;
        req      = '1;
        prev_gnt = '0;
        zero_run = 0;
        for (int i = 0; i < N; i++) begin
            ndone[i] = 0; pending[i] = 0; dropped[i] = 0;
        end
        for (int cyc = 0; cyc < 800 && order.size() < 4; cyc++) begin
            step();
            req_flag = '0;
            if (gnt == '0) begin
                zero_run++;
            end else if (gnt != prev_gnt) begin
                order.push_back(gnt[1] ? 1 : 0);
                if (order.size() > 1) gaps.push_back(zero_run);
                zero_run = 0;
            end
            prev_gnt = gnt;
            for (int i = 0; i < N; i++) begin
                if (req_done[i]) begin
                    pending[i] = 1'b0;
                    ndone[i]++;
                    if (ndone[i] == 3) begin
                        req[i]     = 1'b0;
                        dropped[i] = 1'b1;
                        ndone[i]   = 0;
                    end
                end else if (dropped[i] && !gnt[i]) begin
                    req[i]     = 1'b1;
                    dropped[i] = 1'b0;
                end else if (gnt[i] && !pending[i] && req[i]) begin
                    req_flag[i]          = 1'b1;
                    req_ascii[i*8 +: 8]  = 8'($urandom);
                    pending[i]           = 1'b1;
                end
            end
        end
        chk("rr_grant_count", order.size(), 4);
        for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % 2);
        for (int k = 0; k < gaps.size(); k++) chk("rr_gap", gaps[k], 1);
    endtask

    initial begin
        int k;
        int extra;
        int rd1;
        int pflag;

        sys_rst   = 1'b1;
        init_done = 1'b0;
        req       = '0;
        req_flag  = '0;
        req_ascii = '0;
        req_x     = '0;
        req_y     = '0;
        req_bg    = '0;
        req_fg    = '0;
        req_size  = '0;

        // Reset and init gating.
        step();
        cmp_en = 1'b1;
        repeat (2) step();
        sys_rst = 1'b0;
        chk("rst_gnt", gnt, '0);
        chk("rst_bg", background_color, 16'hE73F);
        chk("rst_ascii", ascii_num, 8'h00);
        req = 2'b01;
        repeat (10) step();
        chk("init_gate_gnt", gnt, 2'b00);
        chk("init_gate_bg", background_color, 16'hE73F);
        init_done = 1'b1;
        step();
        chk("grant_after_init", gnt, 2'b01);

        // Single character.
        eng_lat             = 20;
        req_flag            = 2'b01;
        req_ascii[7:0]      = 8'h2D;
        req_x[8:0]          = 9'd40;
        req_y[8:0]          = 9'd96;
        req_bg[15:0]        = 16'h815B;
        req_fg[15:0]        = 16'h1234;
        req_size[0]         = 1'b1;
        step();
        req_flag = '0;
        chk("sc_flag", show_char_flag, 1'b1);
        chk("sc_ascii", ascii_num, 8'h2D);
        chk("sc_x", start_x, 9'd40);
        chk("sc_y", start_y, 9'd96);
        chk("sc_bg", background_color, 16'h815B);
        chk("pin_model_ascii", m_ascii, 8'h2D);
        chk("pin_model_owner", m_owner, 0);
        req_ascii[7:0] = 8'hFF;
        step();
        chk("sc_flag_one_cycle", show_char_flag, 1'b0);
        for (k = 0; k < 60; k++) begin
            step();
            if (show_char_done) break;
        end
        chk("sc_done_route", req_done, 2'b01);
        chk("sc_frozen", ascii_num, 8'h2D);
        step();
        chk("sc_back_to_grant", gnt, 2'b01);

        // Round-robin handover.
        run_rr();

        // Foreign and extra flags while busy.
        reset_dut();
        eng_lat = 10;
        req     = 2'b01;
        wait_grant("ff_grant", 2'b01);
        req_flag       = 2'b01;
        req_ascii      = {8'h77, 8'h41};
        step();
        req_flag = '0;
        step();
        req_flag  = 2'b11;
        req_ascii = {8'h66, 8'h55};
        step();
        req_flag = '0;
        extra = 0;
        rd1   = 0;
        for (k = 0; k < 60; k++) begin
            if (show_char_flag) extra++;
            if (req_done[1]) rd1++;
            if (show_char_done) break;
            step();
        end
        chk("ff_extra_flags", extra, 0);
        chk("ff_done1", rd1, 0);
        chk("ff_ascii", ascii_num, 8'h41);
        chk("ff_done_route", req_done, 2'b01);

        // Watchdog.
        reset_dut();
        req = 2'b10;
        wait_grant("wd_grant", 2'b10);
        req = 2'b11;
        for (k = 0; k < 40; k++) begin
            step();
            if (timeout_err) break;
        end
        chk("wd_cycles", k + 1, 16);
        chk("pin_model_terr", m_terr, 1'b1);
        step();
        chk("wd_terr_one_cycle", timeout_err, 1'b0);
        chk("wd_gnt_drop", gnt, 2'b00);
        step();
        chk("wd_next_grant", gnt, 2'b01);

        // Reset while a character is in flight.
        reset_dut();
        eng_lat = 10;
        req     = 2'b01;
        wait_grant("mb_grant", 2'b01);
        req_flag       = 2'b01;
        req_ascii[7:0] = 8'h33;
        step();
        req_flag = '0;
        repeat (2) step();
        sys_rst = 1'b1;
        req     = '0;
        repeat (2) step();
        sys_rst = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (show_char_done) break;
            step();
        end
        chk("mb_done_seen", show_char_done, 1'b1);
        chk("mb_req_done", req_done, 2'b00);
        chk("mb_gnt", gnt, 2'b00);
        chk("mb_ascii", ascii_num, 8'h00);
        chk("mb_bg", background_color, 16'hE73F);
        step();
        chk("mb_stays_idle", gnt, 2'b00);

        // Randomized traffic.
        reset_dut();
        stray_en = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            pflag = (ph == 0) ? 30 : (ph == 1) ? 5 : (ph == 2) ? 1 : 60;
            for (int c = 0; c < 600; c++) begin
                step();
                sys_rst = ($urandom_range(0, 599) == 0);
                if (init_done) init_done = ($urandom_range(0, 99) != 0);
                else           init_done = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
                    req_flag[i] = ($urandom_range(0, 99) < pflag);
                end
                req_ascii = AW'($urandom);
                req_x     = XW'($urandom);
                req_y     = XW'($urandom);
                req_bg    = CW'($urandom);
                req_fg    = CW'($urandom);
                req_size  = N'($urandom);
                eng_lat   = $urandom_range(2, 12);
            end
        end
        sys_rst  = 1'b0;
        stray_en = 1'b0;
        req      = '0;
        req_flag = '0;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
